decode_execute_reg: RTL and testbench
=====================================

Name: decode_execute_reg

Overview:
Decode-to-execute pipeline register for the five-stage RV32I core, with load-use interlock, branch flush and a write-back-to-decode register-file bypass.
- Captures the decoded instruction each cycle and presents it to the execute stage: operand indices and data, pc, imm, shamt and operand selects feed the execute forwarding muxes.
- Inserts bubbles and drives the fetch/decode stall.
- Keeps saturating stall and flush counters.

Parameters:
XLEN, 32, datapath width.
CNT_W, 32, width of the stall and flush performance counters.

Ports:
clock  in  1  core clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
d_valid  in  1  decode holds a real instruction.
d_pc  in  XLEN  decode pc.
d_rs1, d_rs2, d_rd  in  5 each  decoded register indices.
d_rs1_data, d_rs2_data  in  XLEN each  register-file read data.
d_imm, d_shamt  in  XLEN each  immediate; zero-extended shift amount.
d_pc_reg1_sel  in  1  operand A is pc.
d_imm_rs2_shamt_sel  in  2  operand B select: 00 rs2, 01 shamt, 1x imm.
d_alu_sel  in  4  ALU operation.
d_reg_wen, d_mem_ren, d_mem_wen  in  1 each  rd write, load, store.
wb_reg_wen  in  1  write-back writes the register file this cycle.
wb_rd  in  5  write-back destination.
wb_data  in  XLEN  write-back data.
ex_flush  in  1  taken branch/jump resolved in execute this cycle.
stall_fd  out  1  hold the fetch and decode registers this cycle.
e_valid  out  1  execute holds a real instruction.
e_pc, e_rs1_data, e_rs2_data, e_imm, e_shamt  out  XLEN each  registered copies.
e_rs1, e_rs2, e_rd  out  5 each  registered indices.
e_pc_reg1_sel, e_imm_rs2_shamt_sel, e_alu_sel  out  1/2/4  registered selects.
e_reg_wen, e_mem_ren, e_mem_wen  out  1 each  registered controls.
stall_count, flush_count  out  CNT_W each  saturating event counters.

Behaviour:
- Latency: one cycle from the decode inputs to the e_* outputs.
- Reset: every registered output goes to 0, and stall_fd is therefore 0. Reset asserted mid-operation discards the in-flight instruction at that edge.
- rs1_used = ~d_pc_reg1_sel.
- rs2_used = (d_imm_rs2_shamt_sel==00) | d_mem_wen.
- lu_hazard = d_valid & e_valid & e_mem_ren & e_rd!=0 & ((rs1_used & d_rs1==e_rd) | (rs2_used & d_rs2==e_rd)).
- stall_fd = lu_hazard & ~ex_flush (combinational).
- Next-state priority at each clock edge: reset > ex_flush > lu_hazard > d_valid > otherwise.
  - ex_flush: load a bubble.
  - lu_hazard: load a bubble; decode holds, so the same instruction is re-presented next cycle.
  - d_valid: capture the instruction.
  - otherwise: load a bubble.
- Bubble: e_valid=0; e_reg_wen/e_mem_ren/e_mem_wen=0; e_rd=e_rs1=e_rs2=0; all data fields, selects and e_alu_sel=0.
- Capture:
  - e_rd = d_reg_wen ? d_rd : 0.
  - e_reg_wen = d_reg_wen & d_rd!=0.
  - Guarantee: no instruction that does not write the register file presents a non-zero e_rd.
- WB bypass at capture:
  - e_rs1_data = (wb_reg_wen & wb_rd!=0 & wb_rd==d_rs1) ? wb_data : d_rs1_data.
  - e_rs2_data uses the same rule with d_rs2.
  - An index of 0 always captures the register-file value.
- A load-use hazard produces exactly one bubble. After the bubble e_valid=0, so the hazard clears and the memory-stage forwarding supplies the load data.
- Simultaneous flush and hazard: the flush wins and stall_fd=0, so the fetch redirect proceeds.
- Counters:
  - stall_count increments on every cycle with stall_fd=1.
  - flush_count increments on every cycle with ex_flush=1.
  - Both hold at all-ones (saturate).
  - Both clear only on reset.

Decomposition:
- Shared package pd_pkg holds:
  - XLEN.
  - The operand-B select encodings (SEL_RS2=00, SEL_SHAMT=01, SEL_IMM=1x).
  - The ALU select width and encodings.
  - The bubble constants.
- Sub-module load_use_detect, combinational: computes rs1_used, rs2_used, lu_hazard and stall_fd.
- The register, bypass and counter logic stay in the top module.

Test Plan:
- Reset held 2 cycles with d_valid=1 -> all e_* outputs=0, stall_fd=0, both counters=0.
- Capture: d_valid=1, add x3,x1,x2, d_rs1_data=5, d_rs2_data=7 -> next cycle e_valid=1, e_rd=3, e_reg_wen=1, e_rs1_data=5, e_rs2_data=7.
- Load-use: lw x5 in execute (e_mem_ren=1, e_rd=5), decode add x6,x5,x1 -> stall_fd=1 for exactly 1 cycle, next cycle e_valid=0, then the add is captured; stall_count=1.
- Load-use cases that must not stall:
  - Decode addi x6,x0,4 (rs2 unused, d_rs2 field=5) against lw x5 in execute -> stall_fd=0.
  - lw x0 in execute with decode rs1=0 -> stall_fd=0.
- WB bypass: wb_reg_wen=1, wb_rd=4, wb_data=0xDEADBEEF, decode rs2=4 with d_rs2_data=0 -> e_rs2_data=0xDEADBEEF. Repeat with wb_rd=0 and decode rs2=0 -> e_rs2_data=0.
- Flush during hazard: ex_flush=1 and lu_hazard=1 in the same cycle -> stall_fd=0, next cycle e_valid=0, flush_count=1, stall_count unchanged. Separately, force both counters to all-ones and hold them there for 3 more cycles -> values stay all-ones.

Source files
------------

// File: rtl/pd_pkg.sv
// Shared definitions for the decode/execute pipeline register: operand-B select
// encodings, ALU select encodings and the constants loaded into a bubble.
package pd_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ALU_SEL_W = 4;

  // Operand B select; bit 1 set means immediate regardless of bit 0.
  localparam logic [1:0] SEL_RS2   = 2'b00;
  localparam logic [1:0] SEL_SHAMT = 2'b01;
  localparam logic [1:0] SEL_IMM   = 2'b10;

  typedef enum logic [ALU_SEL_W-1:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSlt  = 4'd3,
    AluSltu = 4'd4,
    AluXor  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluOr   = 4'd8,
    AluAnd  = 4'd9,
    AluLui  = 4'd10
  } alu_sel_e;

  localparam logic [4:0]           BUBBLE_IDX   = 5'd0;
  localparam logic [ALU_SEL_W-1:0] BUBBLE_ALU   = AluAdd;
  localparam logic [1:0]           BUBBLE_B_SEL = SEL_RS2;

  function automatic logic b_sel_is_rs2(input logic [1:0] sel);
    return sel == SEL_RS2;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use interlock: stalls decode when it reads the destination
// of a load currently sitting in execute, unless execute is flushing.
module load_use_detect
  import pd_pkg::*;
(
  input  logic       d_valid,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic       d_pc_reg1_sel,
  input  logic [1:0] d_imm_rs2_shamt_sel,
  input  logic       d_mem_wen,
  input  logic       e_valid,
  input  logic       e_mem_ren,
  input  logic [4:0] e_rd,
  input  logic       ex_flush,
  output logic       lu_hazard,
  output logic       stall_fd
);

  logic rs1_used;
  logic rs2_used;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_used = ~d_pc_reg1_sel;
    // Stores read rs2 as the store data even though operand B is the immediate.
    rs2_used = b_sel_is_rs2(d_imm_rs2_shamt_sel) | d_mem_wen;
    rs1_hit  = rs1_used & (d_rs1 == e_rd);
    rs2_hit  = rs2_used & (d_rs2 == e_rd);
    lu_hazard = d_valid & e_valid & e_mem_ren & (e_rd != 5'd0) & (rs1_hit | rs2_hit);
    stall_fd  = lu_hazard & ~ex_flush;
  end

endmodule

// File: rtl/decode_execute_reg.sv
// Decode-to-execute pipeline register with load-use bubble insertion, branch
// flush, write-back bypass into the captured operands and saturating counters.
module decode_execute_reg #(
  parameter int unsigned XLEN  = pd_pkg::XLEN,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [XLEN-1:0]  d_pc,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic [4:0]       d_rd,
  input  logic [XLEN-1:0]  d_rs1_data,
  input  logic [XLEN-1:0]  d_rs2_data,
  input  logic [XLEN-1:0]  d_imm,
  input  logic [XLEN-1:0]  d_shamt,
  input  logic             d_pc_reg1_sel,
  input  logic [1:0]       d_imm_rs2_shamt_sel,
  input  logic [3:0]       d_alu_sel,
  input  logic             d_reg_wen,
  input  logic             d_mem_ren,
  input  logic             d_mem_wen,
  input  logic             wb_reg_wen,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ex_flush,
  output logic             stall_fd,
  output logic             e_valid,
  output logic [XLEN-1:0]  e_pc,
  output logic [XLEN-1:0]  e_rs1_data,
  output logic [XLEN-1:0]  e_rs2_data,
  output logic [XLEN-1:0]  e_imm,
  output logic [XLEN-1:0]  e_shamt,
  output logic [4:0]       e_rs1,
  output logic [4:0]       e_rs2,
  output logic [4:0]       e_rd,
  output logic             e_pc_reg1_sel,
  output logic [1:0]       e_imm_rs2_shamt_sel,
  output logic [3:0]       e_alu_sel,
  output logic             e_reg_wen,
  output logic             e_mem_ren,
  output logic             e_mem_wen,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  import pd_pkg::*;

  logic            lu_hazard;
  logic            load_bubble;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  load_use_detect u_load_use_detect (
    .d_valid             (d_valid),
    .d_rs1               (d_rs1),
    .d_rs2               (d_rs2),
    .d_pc_reg1_sel       (d_pc_reg1_sel),
    .d_imm_rs2_shamt_sel (d_imm_rs2_shamt_sel),
    .d_mem_wen           (d_mem_wen),
    .e_valid             (e_valid),
    .e_mem_ren           (e_mem_ren),
    .e_rd                (e_rd),
    .ex_flush            (ex_flush),
    .lu_hazard           (lu_hazard),
    .stall_fd            (stall_fd)
  );

  // The register file is written at the end of this cycle, so decode read stale data.
  always_comb begin
    rs1_fwd = d_rs1_data;
    rs2_fwd = d_rs2_data;
    if (wb_reg_wen && (wb_rd != 5'd0) && (wb_rd == d_rs1)) rs1_fwd = wb_data;
    if (wb_reg_wen && (wb_rd != 5'd0) && (wb_rd == d_rs2)) rs2_fwd = wb_data;
    load_bubble = ex_flush | lu_hazard | ~d_valid;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      e_valid             <= 1'b0;
      e_pc                <= '0;
      e_rs1_data          <= '0;
      e_rs2_data          <= '0;
      e_imm               <= '0;
      e_shamt             <= '0;
      e_rs1               <= BUBBLE_IDX;
      e_rs2               <= BUBBLE_IDX;
      e_rd                <= BUBBLE_IDX;
      e_pc_reg1_sel       <= 1'b0;
      e_imm_rs2_shamt_sel <= BUBBLE_B_SEL;
      e_alu_sel           <= BUBBLE_ALU;
      e_reg_wen           <= 1'b0;
      e_mem_ren           <= 1'b0;
      e_mem_wen           <= 1'b0;
      stall_count         <= '0;
      flush_count         <= '0;
    end else begin
      if (stall_fd && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (ex_flush && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + CNT_W'(1);
      end

      if (load_bubble) begin
        e_valid             <= 1'b0;
        e_pc                <= '0;
        e_rs1_data          <= '0;
        e_rs2_data          <= '0;
        e_imm               <= '0;
        e_shamt             <= '0;
        e_rs1               <= BUBBLE_IDX;
        e_rs2               <= BUBBLE_IDX;
        e_rd                <= BUBBLE_IDX;
        e_pc_reg1_sel       <= 1'b0;
        e_imm_rs2_shamt_sel <= BUBBLE_B_SEL;
        e_alu_sel           <= BUBBLE_ALU;
        e_reg_wen           <= 1'b0;
        e_mem_ren           <= 1'b0;
        e_mem_wen           <= 1'b0;
      end else begin
        e_valid             <= 1'b1;
        e_pc                <= d_pc;
        e_rs1_data          <= rs1_fwd;
        e_rs2_data          <= rs2_fwd;
        e_imm               <= d_imm;
        e_shamt             <= d_shamt;
        e_rs1               <= d_rs1;
        e_rs2               <= d_rs2;
        // Non-writing instructions carry rd=0 so forwarding never matches them.
        e_rd                <= d_reg_wen ? d_rd : BUBBLE_IDX;
        e_pc_reg1_sel       <= d_pc_reg1_sel;
        e_imm_rs2_shamt_sel <= d_imm_rs2_shamt_sel;
        e_alu_sel           <= d_alu_sel;
        e_reg_wen           <= d_reg_wen & (d_rd != 5'd0);
        e_mem_ren           <= d_mem_ren;
        e_mem_wen           <= d_mem_wen;
      end
    end
  end

endmodule

// File: tb/tb_decode_execute_reg.sv
// Self-checking bench for decode_execute_reg: directed scenarios plus randomized
// traffic against an instruction-level reference model.
module tb_decode_execute_reg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset;
  logic             d_valid;
  logic [XLEN-1:0]  d_pc, d_rs1_data, d_rs2_data, d_imm, d_shamt;
  logic [4:0]       d_rs1, d_rs2, d_rd;
  logic             d_pc_reg1_sel;
  logic [1:0]       d_imm_rs2_shamt_sel;
  logic [3:0]       d_alu_sel;
  logic             d_reg_wen, d_mem_ren, d_mem_wen;
  logic             wb_reg_wen;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             ex_flush;
  logic             stall_fd;
  logic             e_valid;
  logic [XLEN-1:0]  e_pc, e_rs1_data, e_rs2_data, e_imm, e_shamt;
  logic [4:0]       e_rs1, e_rs2, e_rd;
  logic             e_pc_reg1_sel;
  logic [1:0]       e_imm_rs2_shamt_sel;
  logic [3:0]       e_alu_sel;
  logic             e_reg_wen, e_mem_ren, e_mem_wen;
  logic [CNT_W-1:0] stall_count, flush_count;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] shamt;
    logic            pc_sel;
    logic [1:0]      b_sel;
    logic [3:0]      alu;
    logic            reg_wen;
    logic            mem_ren;
    logic            mem_wen;
  } ex_t;

  ex_t m;
  ex_t dut_ex;
  int  m_stall, m_flush;
  int  checks, errors;

  assign dut_ex = {e_valid, e_pc, e_rs1, e_rs2, e_rd, e_rs1_data, e_rs2_data, e_imm, e_shamt,
                   e_pc_reg1_sel, e_imm_rs2_shamt_sel, e_alu_sel, e_reg_wen, e_mem_ren,
                   e_mem_wen};

  decode_execute_reg #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .d_valid             (d_valid),
    .d_pc                (d_pc),
    .d_rs1               (d_rs1),
    .d_rs2               (d_rs2),
    .d_rd                (d_rd),
    .d_rs1_data          (d_rs1_data),
    .d_rs2_data          (d_rs2_data),
    .d_imm               (d_imm),
    .d_shamt             (d_shamt),
    .d_pc_reg1_sel       (d_pc_reg1_sel),
    .d_imm_rs2_shamt_sel (d_imm_rs2_shamt_sel),
    .d_alu_sel           (d_alu_sel),
    .d_reg_wen           (d_reg_wen),
    .d_mem_ren           (d_mem_ren),
    .d_mem_wen           (d_mem_wen),
    .wb_reg_wen          (wb_reg_wen),
    .wb_rd               (wb_rd),
    .wb_data             (wb_data),
    .ex_flush            (ex_flush),
    .stall_fd            (stall_fd),
    .e_valid             (e_valid),
    .e_pc                (e_pc),
    .e_rs1_data          (e_rs1_data),
    .e_rs2_data          (e_rs2_data),
    .e_imm               (e_imm),
    .e_shamt             (e_shamt),
    .e_rs1               (e_rs1),
    .e_rs2               (e_rs2),
    .e_rd                (e_rd),
    .e_pc_reg1_sel       (e_pc_reg1_sel),
    .e_imm_rs2_shamt_sel (e_imm_rs2_shamt_sel),
    .e_alu_sel           (e_alu_sel),
    .e_reg_wen           (e_reg_wen),
    .e_mem_ren           (e_mem_ren),
    .e_mem_wen           (e_mem_wen),
    .stall_count         (stall_count),
    .flush_count         (flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Decode wants a source register that the load in execute has not produced yet.
  function automatic logic model_hazard();
    logic reads_a, reads_b;
    reads_a = !d_pc_reg1_sel;
    reads_b = (d_imm_rs2_shamt_sel == 2'b00) || d_mem_wen;
    return d_valid && m.valid && m.mem_ren && (m.rd != 5'd0) &&
           ((reads_a && d_rs1 == m.rd) || (reads_b && d_rs2 == m.rd));
  endfunction

  function automatic logic [XLEN-1:0] reg_value(input logic [4:0] idx,
                                                input logic [XLEN-1:0] rf_val);
    if (idx != 5'd0 && wb_reg_wen && wb_rd == idx) return wb_data;
    return rf_val;
  endfunction

  task automatic tick();
    ex_t nxt;
    int  ns, nf;
    logic hz;
    hz  = model_hazard();
    nxt = '0;
    ns  = m_stall;
    nf  = m_flush;
    if (reset) begin
      ns = 0;
      nf = 0;
    end else begin
      if (hz && !ex_flush) ns = (m_stall >= CNT_MAX) ? CNT_MAX : m_stall + 1;
      if (ex_flush) nf = (m_flush >= CNT_MAX) ? CNT_MAX : m_flush + 1;
      if (d_valid && !ex_flush && !hz) begin
        nxt.valid    = 1'b1;
        nxt.pc       = d_pc;
        nxt.rs1      = d_rs1;
        nxt.rs2      = d_rs2;
        nxt.rd       = d_reg_wen ? d_rd : 5'd0;
        nxt.rs1_data = reg_value(d_rs1, d_rs1_data);
        nxt.rs2_data = reg_value(d_rs2, d_rs2_data);
        nxt.imm      = d_imm;
        nxt.shamt    = d_shamt;
        nxt.pc_sel   = d_pc_reg1_sel;
        nxt.b_sel    = d_imm_rs2_shamt_sel;
        nxt.alu      = d_alu_sel;
        nxt.reg_wen  = d_reg_wen && (d_rd != 5'd0);
        nxt.mem_ren  = d_mem_ren;
        nxt.mem_wen  = d_mem_wen;
      end
    end
    @(posedge clock);
    m       = nxt;
    m_stall = ns;
    m_flush = nf;
    #1;
  endtask

  task automatic idle();
    d_valid = 0; d_pc = '0; d_rs1 = '0; d_rs2 = '0; d_rd = '0;
    d_rs1_data = '0; d_rs2_data = '0; d_imm = '0; d_shamt = '0;
    d_pc_reg1_sel = 0; d_imm_rs2_shamt_sel = 2'b00; d_alu_sel = '0;
    d_reg_wen = 0; d_mem_ren = 0; d_mem_wen = 0;
    wb_reg_wen = 0; wb_rd = '0; wb_data = '0; ex_flush = 0;
  endtask

  task automatic present(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic reg_wen, input logic mem_ren, input logic mem_wen,
                         input logic pc_sel, input logic [1:0] b_sel);
    d_valid = 1; d_rd = rd; d_rs1 = rs1; d_rs2 = rs2;
    d_reg_wen = reg_wen; d_mem_ren = mem_ren; d_mem_wen = mem_wen;
    d_pc_reg1_sel = pc_sel; d_imm_rs2_shamt_sel = b_sel;
    d_pc = $urandom; d_imm = $urandom; d_shamt = XLEN'($urandom_range(0, 31));
    d_rs1_data = $urandom; d_rs2_data = $urandom; d_alu_sel = 4'($urandom_range(0, 10));
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    present(5'd3, 5'd1, 5'd2, 1, 1, 0, 0, 2'b00);
    tick();
    tick();
    checks++;
    if (dut_ex !== '0) begin
      errors++;
      $display("FAIL reset_e_outputs: got %h want 0", dut_ex);
    end
    checks++;
    if (stall_fd !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_fd: got %b want 0", stall_fd);
    end
    checks++;
    if (stall_count !== '0 || flush_count !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_count, flush_count);
    end
    reset = 0;
    idle();
  endtask

  task automatic test_capture();
    present(5'd3, 5'd1, 5'd2, 1, 0, 0, 0, 2'b00);
    d_rs1_data = 32'd5;
    d_rs2_data = 32'd7;
    tick();
    checks++;
    if (e_valid !== 1'b1 || e_rd !== 5'd3 || e_reg_wen !== 1'b1) begin
      errors++;
      $display("FAIL capture_ctrl: got valid=%b rd=%0d wen=%b want 1/3/1",
               e_valid, e_rd, e_reg_wen);
    end
    checks++;
    if (e_rs1_data !== 32'd5 || e_rs2_data !== 32'd7) begin
      errors++;
      $display("FAIL capture_data: got %0d/%0d want 5/7", e_rs1_data, e_rs2_data);
    end
    checks++;
    if (dut_ex !== m) begin
      errors++;
      $display("FAIL capture_all: got %h want %h", dut_ex, m);
    end
  endtask

  task automatic test_load_use();
    present(5'd5, 5'd2, 5'd0, 1, 1, 0, 0, 2'b10);
    tick();
    present(5'd6, 5'd5, 5'd1, 1, 0, 0, 0, 2'b00);
    #1;
    checks++;
    if (stall_fd !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: got %b want 1", stall_fd);
    end
    tick();
    checks++;
    if (e_valid !== 1'b0 || stall_fd !== 1'b0) begin
      errors++;
      $display("FAIL load_use_bubble: got valid=%b stall=%b want 0/0", e_valid, stall_fd);
    end
    tick();
    checks++;
    if (e_valid !== 1'b1 || e_rd !== 5'd6 || e_rs1 !== 5'd5) begin
      errors++;
      $display("FAIL load_use_replay: got valid=%b rd=%0d rs1=%0d want 1/6/5",
               e_valid, e_rd, e_rs1);
    end
    checks++;
    if (stall_count !== 4'd1) begin
      errors++;
      $display("FAIL load_use_count: got %0d want 1", stall_count);
    end
  endtask

  task automatic test_no_stall();
    present(5'd5, 5'd2, 5'd0, 1, 1, 0, 0, 2'b10);
    tick();
    present(5'd6, 5'd0, 5'd5, 1, 0, 0, 0, 2'b10);
    #1;
    checks++;
    if (stall_fd !== 1'b0) begin
      errors++;
      $display("FAIL no_stall_imm: got %b want 0", stall_fd);
    end
    tick();
    present(5'd0, 5'd3, 5'd0, 1, 1, 0, 0, 2'b10);
    tick();
    checks++;
    if (e_rd !== 5'd0 || e_reg_wen !== 1'b0 || e_mem_ren !== 1'b1) begin
      errors++;
      $display("FAIL lw_x0_capture: got rd=%0d wen=%b ren=%b want 0/0/1",
               e_rd, e_reg_wen, e_mem_ren);
    end
    present(5'd7, 5'd0, 5'd0, 1, 0, 0, 0, 2'b00);
    #1;
    checks++;
    if (stall_fd !== 1'b0) begin
      errors++;
      $display("FAIL no_stall_x0: got %b want 0", stall_fd);
    end
    tick();
    // Store data comes from rs2 even with an immediate operand B.
    present(5'd5, 5'd2, 5'd0, 1, 1, 0, 0, 2'b10);
    tick();
    present(5'd0, 5'd1, 5'd5, 0, 0, 1, 0, 2'b10);
    #1;
    checks++;
    if (stall_fd !== 1'b1) begin
      errors++;
      $display("FAIL store_rs2_stall: got %b want 1", stall_fd);
    end
    tick();
    checks++;
    if (e_valid !== 1'b0) begin
      errors++;
      $display("FAIL store_bubble: got valid=%b want 0", e_valid);
    end
    tick();
    idle();
  endtask

  task automatic test_wb_bypass();
    idle();
    tick();
    present(5'd7, 5'd1, 5'd4, 1, 0, 0, 0, 2'b00);
    d_rs1_data = 32'h0000_1111;
    d_rs2_data = 32'h0;
    wb_reg_wen = 1; wb_rd = 5'd4; wb_data = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (e_rs2_data !== 32'hDEAD_BEEF || e_rs1_data !== 32'h0000_1111) begin
      errors++;
      $display("FAIL wb_bypass_rs2: got %h/%h want 00001111/deadbeef", e_rs1_data, e_rs2_data);
    end
    wb_rd = 5'd0; d_rs2 = 5'd0; d_rs2_data = 32'h0;
    tick();
    checks++;
    if (e_rs2_data !== 32'h0) begin
      errors++;
      $display("FAIL wb_bypass_x0: got %h want 0", e_rs2_data);
    end
    idle();
  endtask

  task automatic test_flush_hazard();
    int sc;
    present(5'd5, 5'd2, 5'd0, 1, 1, 0, 0, 2'b10);
    tick();
    present(5'd6, 5'd5, 5'd1, 1, 0, 0, 0, 2'b00);
    ex_flush = 1;
    #1;
    checks++;
    if (stall_fd !== 1'b0) begin
      errors++;
      $display("FAIL flush_hazard_stall: got %b want 0", stall_fd);
    end
    sc = m_stall;
    tick();
    checks++;
    if (e_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble: got valid=%b want 0", e_valid);
    end
    checks++;
    if (flush_count !== 4'd1 || stall_count !== CNT_W'(sc)) begin
      errors++;
      $display("FAIL flush_counts: got flush=%0d stall=%0d want 1/%0d",
               flush_count, stall_count, sc);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic exp_stall;
      present(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
              1'($urandom), 2'($urandom));
      d_valid    = ($urandom_range(0, 3) != 0);
      wb_reg_wen = 1'($urandom);
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      ex_flush   = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 39) == 0);
      #1;
      exp_stall = model_hazard() && !ex_flush;
      checks++;
      if (stall_fd !== exp_stall) begin
        errors++;
        $display("FAIL rand_stall[%0d]: got %b want %b", i, stall_fd, exp_stall);
      end
      tick();
      checks++;
      if (dut_ex !== m) begin
        errors++;
        $display("FAIL rand_ex[%0d]: got %h want %h", i, dut_ex, m);
      end
      checks++;
      if (stall_count !== CNT_W'(m_stall) || flush_count !== CNT_W'(m_flush)) begin
        errors++;
        $display("FAIL rand_counts[%0d]: got %0d/%0d want %0d/%0d",
                 i, stall_count, flush_count, m_stall, m_flush);
      end
    end
    reset = 0;
    idle();
  endtask

  task automatic test_saturate();
    idle();
    ex_flush = 1;
    repeat (20) tick();
    ex_flush = 0;
    for (int i = 0; i < 20; i++) begin
      present(5'd5, 5'd2, 5'd0, 1, 1, 0, 0, 2'b10);
      tick();
      present(5'd6, 5'd5, 5'd1, 1, 0, 0, 0, 2'b00);
      tick();
      tick();
    end
    checks++;
    if (stall_count !== 4'hF || flush_count !== 4'hF) begin
      errors++;
      $display("FAIL saturate_reach: got %0d/%0d want 15/15", stall_count, flush_count);
    end
    for (int i = 0; i < 3; i++) begin
      present(5'd5, 5'd2, 5'd0, 1, 1, 0, 0, 2'b10);
      tick();
      present(5'd6, 5'd5, 5'd1, 1, 0, 0, 0, 2'b00);
      #1;
      checks++;
      if (stall_fd !== 1'b1) begin
        errors++;
        $display("FAIL saturate_stall_event[%0d]: got %b want 1", i, stall_fd);
      end
      tick();
      ex_flush = 1;
      tick();
      ex_flush = 0;
      checks++;
      if (stall_count !== 4'hF || flush_count !== 4'hF) begin
        errors++;
        $display("FAIL saturate_hold[%0d]: got %0d/%0d want 15/15",
                 i, stall_count, flush_count);
      end
    end
    idle();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    m       = '0;
    m_stall = 0;
    m_flush = 0;
    reset   = 1;
    idle();
    test_reset();
    test_capture();
    test_load_use();
    test_no_stall();
    test_wb_bypass();
    test_flush_hazard();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
